// File: rtl/write_back_unit_pkg.sv
// Shared CPU constants for the write-back path and register file.
// Holds register/queue sizing and the write-queue occupancy encoding.
package write_back_unit_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 2;
  localparam int DEPTH  = 2;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [CNT_W-1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Pending register-write queue: push at tail, pop from head.
// Head and all slots are visible combinationally for forwarding.
module wb_fifo
  import write_back_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [REG_AW-1:0] head_rd,
  output logic [DATA_W-1:0] head_data,
  output logic [REG_AW-1:0] ent_rd   [DEPTH],
  output logic [DATA_W-1:0] ent_data [DEPTH]
);

  q_state_e          state;
  q_state_e          state_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [REG_AW-1:0] mem_rd   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (state != Q_FULL);
  assign do_pop  = pop && (state != Q_EMPTY);

  // Occupancy next-state from push/pop pairing
  always_comb begin
    state_nxt = state;
    case ({do_push, do_pop})
      2'b10: state_nxt = (state == Q_EMPTY) ? Q_ONE : Q_FULL;
      2'b01: state_nxt = (state == Q_FULL) ? Q_ONE : Q_EMPTY;
      default: state_nxt = state;
    endcase
  end

  // Occupancy and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= Q_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Slot storage, left uninitialised on reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_rd[wr_ptr]   <= push_rd;
      mem_data[wr_ptr] <= push_data;
    end
  end

  assign count     = state;
  assign head_rd   = mem_rd[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign ent_rd    = mem_rd;
  assign ent_data  = mem_data;

endmodule

// File: rtl/write_back_unit.sv
// Write-back stage: arbitrates ALU/load results into a pending queue,
// issues one register-file write per cycle, forwards youngest values.
module write_back_unit
  import write_back_unit_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              AluValid,
  input  logic [REG_AW-1:0] AluRd,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluReady,
  input  logic              LoadValid,
  input  logic [REG_AW-1:0] LoadRd,
  input  logic [DATA_W-1:0] LoadData,
  output logic              LoadReady,
  input  logic              WbHold,
  output logic [REG_AW-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [REG_AW-1:0] RS,
  input  logic [REG_AW-1:0] RT,
  input  logic [DATA_W-1:0] RegRS,
  input  logic [DATA_W-1:0] RegRT,
  output logic [DATA_W-1:0] FwdRS,
  output logic [DATA_W-1:0] FwdRT,
  output logic              Pending,
  output logic              Full
);

  logic              rdy_en;
  logic              load_fire;
  logic              alu_fire;
  logic              push;
  logic [REG_AW-1:0] push_rd;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  idx;
  logic [REG_AW-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  logic [REG_AW-1:0] ent_rd   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  // Keeps both Ready outputs low until the first edge after reset
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  assign Full      = (count == CNT_W'(DEPTH));
  assign Pending   = (count != '0) || RegWrite;
  assign LoadReady = rdy_en && !Full;
  assign AluReady  = rdy_en && !Full && !LoadValid;
  assign load_fire = LoadValid && LoadReady;
  assign alu_fire  = AluValid && AluReady;
  assign push      = load_fire || alu_fire;
  assign pop       = (count != '0) && !WbHold;

  // Select the accepted channel; load wins when both are offered
  always_comb begin
    push_rd   = AluRd;
    push_data = AluData;
    unique case (1'b1)
      load_fire: begin
        push_rd   = LoadRd;
        push_data = LoadData;
      end
      default: begin
        push_rd   = AluRd;
        push_data = AluData;
      end
    endcase
  end

  wb_fifo u_fifo (
    .clk       (Clock),
    .rst_n     (Reset_n),
    .push      (push),
    .push_rd   (push_rd),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .rd_ptr    (rd_ptr),
    .head_rd   (head_rd),
    .head_data (head_data),
    .ent_rd    (ent_rd),
    .ent_data  (ent_data)
  );

  // Register-file write port; holds address/data between issues
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= pop;
      if (pop) begin
        RD        <= head_rd;
        WriteData <= head_data;
      end
    end
  end

  // Forwarding: oldest first so the youngest match overrides
  always_comb begin
    FwdRS = RegRS;
    FwdRT = RegRT;
    idx   = rd_ptr;
    if (RegWrite && (RD == RS)) FwdRS = WriteData;
    if (RegWrite && (RD == RT)) FwdRT = WriteData;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count)) begin
        if (ent_rd[idx] == RS) FwdRS = ent_data[idx];
        if (ent_rd[idx] == RT) FwdRT = ent_data[idx];
      end
      idx = ptr_inc(idx);
    end
  end

endmodule
